// File: rtl/pc_fetch_unit_pkg.sv
// Shared types and constants for the fetch stage.
//   pc_src_t      : next-PC select from the branch/jump resolver (2'b11 behaves as PC_PLUS4)
//   fetch_state_t : request sequencer states
//   RESET_PC_DEFAULT : default PC loaded on reset
package pc_fetch_unit_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    PC_PLUS4  = 2'b00,
    PC_TARGET = 2'b01,
    PC_JALR   = 2'b10
  } pc_src_t;

  typedef enum logic [1:0] {
    REQ  = 2'b00,
    WAIT = 2'b01,
    ERR  = 2'b10
  } fetch_state_t;

  // Only branch/jal and jalr selects move the PC off the sequential path.
  function automatic logic is_redirect_src(input logic [1:0] src);
    return (src == PC_TARGET) || (src == PC_JALR);
  endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory request/response plus the decode-facing
// instruction output.
//   master : the fetch unit (drives requests and the instruction output)
//   slave  : memory + decode side (drives ready/response/instr_ready)
interface pc_fetch_unit_if #(
  parameter int unsigned XLEN = 32
) ();

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            instr_valid;
  logic            instr_ready;
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] instr_pc;
  logic [XLEN-1:0] instr_pc_plus4;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid, imem_rsp_data,
    output instr_valid, instr, instr_pc, instr_pc_plus4,
    input  instr_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid, imem_rsp_data,
    input  instr_valid, instr, instr_pc, instr_pc_plus4,
    output instr_ready
  );

endinterface

// File: rtl/fetch_out_reg.sv
// One-entry valid/ready output register between fetch and decode.
//   load_i   : capture data/pc/pc_plus4 and set valid
//   flush_i  : clear valid (wins over load and the handshake)
//   ready_i  : downstream accepts; valid drops unless reloaded the same cycle
//   valid_o, data_o, pc_o, pc_plus4_o : registered outputs, stable while valid & !ready
module fetch_out_reg #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            load_i,
  input  logic            flush_i,
  input  logic            ready_i,
  input  logic [XLEN-1:0] data_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] pc_plus4_i,
  output logic            valid_o,
  output logic [XLEN-1:0] data_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus4_o
);

  logic            valid_q, valid_d;
  logic [XLEN-1:0] data_q, data_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pc_plus4_q, pc_plus4_d;

  always_comb begin
    valid_d    = valid_q;
    data_d     = data_q;
    pc_d       = pc_q;
    pc_plus4_d = pc_plus4_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d    = 1'b1;
      data_d     = data_i;
      pc_d       = pc_i;
      pc_plus4_d = pc_plus4_i;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q    <= 1'b0;
      data_q     <= '0;
      pc_q       <= '0;
      pc_plus4_q <= '0;
    end else begin
      valid_q    <= valid_d;
      data_q     <= data_d;
      pc_q       <= pc_d;
      pc_plus4_q <= pc_plus4_d;
    end
  end

  assign valid_o    = valid_q;
  assign data_o     = data_q;
  assign pc_o       = pc_q;
  assign pc_plus4_o = pc_plus4_q;

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch stage: holds the architectural PC, sequences one-outstanding instruction-memory
// reads and hands fetched words to decode through a one-entry output register.
//   clk, rst_n        : clock, asynchronous active-low reset
//   pc_src, redir_valid, imm_target, alu_target : redirect request from the resolver
//   bus (master)      : imem request/response and decode-facing instruction output
//   misalign_err      : sticky flag, set by a redirect to a non-word-aligned target
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      pc_src,
  input  logic            redir_valid,
  input  logic [XLEN-1:0] imm_target,
  input  logic [XLEN-1:0] alu_target,
  pc_fetch_unit_if.master bus,
  output logic            misalign_err
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            squash_q, squash_d;
  logic            misalign_q, misalign_d;

  logic [XLEN-1:0] target;
  logic [XLEN-1:0] pc_plus4;
  logic            redirect;
  logic            misaligned;
  logic            req_valid;
  logic            req_fire;
  logic            out_load;
  logic            out_flush;
  logic            out_valid;

  // jalr clears bit 0 of the ALU result; bit 1 is still checked for alignment.
  assign target     = (pc_src == PC_JALR) ? (alu_target & ~XLEN'(1)) : imm_target;
  assign misaligned = |target[1:0];
  assign redirect   = redir_valid && is_redirect_src(pc_src) && (state_q != ERR);
  assign pc_plus4   = pc_q + XLEN'(4);

  // Only request when the fetched word will have somewhere to go.
  assign req_valid = rst_n && (state_q == REQ) && (!out_valid || bus.instr_ready);
  assign req_fire  = req_valid && bus.imem_req_ready;

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = pc_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    squash_d   = squash_q;
    misalign_d = misalign_q;
    out_load   = 1'b0;
    out_flush  = 1'b0;

    unique case (state_q)
      REQ: begin
        if (req_fire) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (bus.imem_rsp_valid) begin
          state_d = REQ;
          if (squash_q) begin
            squash_d = 1'b0;
          end else begin
            out_load = 1'b1;
            pc_d     = pc_plus4;
          end
        end
      end
      ERR: begin
      end
      default: begin
        state_d = ERR;
      end
    endcase

    // A redirect overrides any same-cycle response load and output handshake.
    if (redirect) begin
      out_load  = 1'b0;
      out_flush = 1'b1;
      if (misaligned) begin
        state_d    = ERR;
        misalign_d = 1'b1;
        squash_d   = 1'b0;
      end else begin
        pc_d = target;
        // A response arriving this very cycle is already dropped, so only a request
        // still in flight after this edge needs squashing.
        squash_d = req_fire || ((state_q == WAIT) && !bus.imem_rsp_valid);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= REQ;
      pc_q       <= RESET_PC;
      squash_q   <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      squash_q   <= squash_d;
      misalign_q <= misalign_d;
    end
  end

  assign misalign_err    = misalign_q;
  assign bus.instr_valid = out_valid;

  fetch_out_reg #(
    .XLEN (XLEN)
  ) u_out_reg (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .load_i     (out_load),
    .flush_i    (out_flush),
    .ready_i    (bus.instr_ready),
    .data_i     (bus.imem_rsp_data),
    .pc_i       (pc_q),
    .pc_plus4_i (pc_plus4),
    .valid_o    (out_valid),
    .data_o     (bus.instr),
    .pc_o       (bus.instr_pc),
    .pc_plus4_o (bus.instr_pc_plus4)
  );

endmodule
